// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake and the instruction-memory write port of
// the program loader.
//   in_valid / in_data / in_ready : byte stream into the loader
//   wr_en / wr_addr / wr_data     : write port toward instruction memory
// Modports:
//   master : the loader (consumes bytes, drives the write port)
//   slave  : the environment (supplies bytes, observes the write port)
// -----------------------------------------------------------------------------
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Write-side companion to the instruction memory. It optionally fills every
// word with NOP_WORD (CLEAR), then packs an incoming byte stream into
// little-endian 32-bit words and writes them at word-aligned byte addresses
// (LOAD). The core is held via cpu_hold until the load completes.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : one-cycle load request, honoured only in IDLE or DONE
//   num_words      : words to load, sampled on an accepted start (clamped)
//   bus            : byte stream in + memory write port (imem_loader_if.master)
//   words_loaded   : program words written by the current load
//   busy           : high in CLEAR or LOAD
//   done           : level, load complete
//   cpu_hold       : core must stay stalled while high
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned CNT_W    = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000000D,
    parameter bit          FILL_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    imem_loader_if.master    bus,
    output logic [CNT_W-1:0] words_loaded,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] n_r;            // latched word count, already clamped
    logic [CNT_W-1:0] word_idx_r;     // next word to write (CLEAR and LOAD)
    logic [1:0]       byte_idx_r;     // position of the next byte in its word
    logic [23:0]      asm_r;          // low three bytes of the word in progress
    logic             in_ready_r;
    logic             wr_en_r;
    logic [31:0]      wr_addr_r;
    logic [31:0]      wr_data_r;
    logic [CNT_W-1:0] words_loaded_r;
    logic             busy_r;
    logic             done_r;
    logic             cpu_hold_r;
    logic             byte_xfer_s;

    // Clamp a requested word count to the memory depth.
    function automatic logic [CNT_W-1:0] clamp_words(input logic [CNT_W-1:0] req);
        return (req > DEPTH_C) ? DEPTH_C : req;
    endfunction

    // Byte address of a word index (same addressing as the PC).
    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
        return {{(30 - CNT_W){1'b0}}, idx, 2'b00};
    endfunction

    // A byte moves only when the registered ready meets a valid byte.
    assign byte_xfer_s = in_ready_r & bus.in_valid;

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            n_r            <= '0;
            word_idx_r     <= '0;
            byte_idx_r     <= 2'd0;
            asm_r          <= 24'h000000;
            in_ready_r     <= 1'b0;
            wr_en_r        <= 1'b0;
            wr_addr_r      <= 32'h00000000;
            wr_data_r      <= 32'h00000000;
            words_loaded_r <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            cpu_hold_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    wr_en_r    <= 1'b0;
                    in_ready_r <= 1'b0;
                    if (start) begin
                        n_r            <= clamp_words(num_words);
                        words_loaded_r <= '0;
                        done_r         <= 1'b0;
                        cpu_hold_r     <= 1'b1;
                        busy_r         <= 1'b1;
                        byte_idx_r     <= 2'd0;
                        asm_r          <= 24'h000000;
                        if (FILL_EN) begin
                            // First fill write (k=0) is issued right away.
                            state_r    <= ST_CLEAR;
                            wr_en_r    <= 1'b1;
                            wr_addr_r  <= 32'h00000000;
                            wr_data_r  <= NOP_WORD;
                            word_idx_r <= ONE_C;
                        end else begin
                            state_r    <= ST_LOAD;
                            word_idx_r <= '0;
                            // Empty program: LOAD drops straight to DONE.
                            in_ready_r <= (clamp_words(num_words) != '0);
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end

                ST_CLEAR: begin
                    if (word_idx_r < DEPTH_C) begin
                        wr_en_r    <= 1'b1;
                        wr_addr_r  <= word_addr(word_idx_r);
                        wr_data_r  <= NOP_WORD;
                        word_idx_r <= word_idx_r + ONE_C;
                    end else begin
                        // Write k=DEPTH-1 was the cycle just finishing.
                        wr_en_r    <= 1'b0;
                        word_idx_r <= '0;
                        if (n_r == '0) begin
                            state_r    <= ST_DONE;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r    <= ST_LOAD;
                            in_ready_r <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    wr_en_r <= 1'b0;
                    if (n_r == '0) begin
                        state_r    <= ST_DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        cpu_hold_r <= 1'b0;
                        in_ready_r <= 1'b0;
                    end else if (byte_xfer_s) begin
                        if (byte_idx_r == 2'd3) begin
                            wr_en_r        <= 1'b1;
                            wr_addr_r      <= word_addr(word_idx_r);
                            wr_data_r      <= {bus.in_data, asm_r};
                            words_loaded_r <= words_loaded_r + ONE_C;
                            word_idx_r     <= word_idx_r + ONE_C;
                            byte_idx_r     <= 2'd0;
                            if (word_idx_r == (n_r - ONE_C)) begin
                                // Final write lands in the first DONE cycle.
                                state_r    <= ST_DONE;
                                in_ready_r <= 1'b0;
                                busy_r     <= 1'b0;
                                done_r     <= 1'b1;
                                cpu_hold_r <= 1'b0;
                            end else begin
                                state_r <= ST_LOAD;
                            end
                        end else begin
                            case (byte_idx_r)
                                2'd0:    asm_r[7:0]   <= bus.in_data;
                                2'd1:    asm_r[15:8]  <= bus.in_data;
                                2'd2:    asm_r[23:16] <= bus.in_data;
                                default: asm_r        <= asm_r;
                            endcase
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    wr_en_r    <= 1'b0;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    cpu_hold_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign words_loaded  = words_loaded_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign cpu_hold      = cpu_hold_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader with default parameters (DEPTH=128, CNT_W=8,
// NOP_WORD=0x0000000D, FILL_EN=1). Outputs are observed on the falling edge;
// a monitor records every write-port cycle into queues.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] num_words;
    logic [7:0] words_loaded;
    logic       busy;
    logic       done;
    logic       cpu_hold;

    imem_loader_if bus_if ();

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_words    (num_words),
        .bus          (bus_if),
        .words_loaded (words_loaded),
        .busy         (busy),
        .done         (done),
        .cpu_hold     (cpu_hold)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rdy_low = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.wr_en === 1'b1) begin
            wq_addr.push_back(bus_if.wr_addr);
            wq_data.push_back(bus_if.wr_data);
        end
    end

    task automatic clear_q;
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus_if.in_valid = 1'b0;
            @(negedge clk);
            if (chk && bus_if.in_ready !== 1'b1) rdy_low++;
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        for (int t = 0; t < 400 && !ok; t++) begin
            if (bus_if.in_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept: byte %h not accepted, got ready=%b required 1", b, bus_if.in_ready);
        end
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got done=%b required 1 within %0d cycles", done, budget);
        end
    endtask

    task automatic pulse_start(input logic [7:0] n);
        @(negedge clk);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        num_words = 8'd0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", bus_if.in_ready); end
        checks++; if (bus_if.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b required 0", bus_if.wr_en); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b required 1", cpu_hold); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b required 00", {busy, done}); end
        checks++; if (bus_if.wr_addr !== 32'h0 || bus_if.wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_bus: got %h/%h required 0/0", bus_if.wr_addr, bus_if.wr_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, cpu_hold} !== 3'b001) begin errors++; $display("FAIL idle_state: got %b required 001", {busy, done, cpu_hold}); end
        // Asynchronous reset in the middle of CLEAR
        pulse_start(8'd1);
        repeat (4) @(negedge clk);
        checks++; if (bus_if.wr_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL clear_active: got wr_en=%b busy=%b required 1 1", bus_if.wr_en, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_if.wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_rst_wr: got wr_en=%b busy=%b required 0 0", bus_if.wr_en, busy); end
        checks++; if (bus_if.wr_addr !== 32'h0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL async_rst_addr: got addr=%h hold=%b required 0 1", bus_if.wr_addr, cpu_hold); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] prog [0:7];
        int t0, lat, bad, rdy_hi;
        prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        clear_q();
        @(negedge clk);
        t0 = cyc;
        start = 1'b1; num_words = 8'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(prog[i], 0, 1'b0);
        bus_if.in_valid = 1'b0;
        wait_done(50);
        lat = cyc - t0;
        checks++; if (lat !== 137) begin errors++; $display("FAIL b2b_latency: got %0d required 137", lat); end
        repeat (2) @(negedge clk);
        checks++; if (wq_data.size() !== 130) begin errors++; $display("FAIL b2b_nwrites: got %0d required 130", wq_data.size()); end
        bad = 0;
        for (int k = 0; k < 128 && k < wq_data.size(); k++)
            if (wq_addr[k] !== 32'(4 * k) || wq_data[k] !== 32'h0000000D) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL clear_writes: got %0d bad entries required 0", bad); end
        if (wq_data.size() == 130) begin
            checks++; if (wq_data[128] !== 32'h00500513 || wq_addr[128] !== 32'h0) begin errors++; $display("FAIL word0: got %h@%h required 00500513@0", wq_data[128], wq_addr[128]); end
            checks++; if (wq_data[129] !== 32'h00A00593 || wq_addr[129] !== 32'h4) begin errors++; $display("FAIL word1: got %h@%h required 00a00593@4", wq_data[129], wq_addr[129]); end
        end
        checks++; if ({done, cpu_hold, busy} !== 3'b100) begin errors++; $display("FAIL b2b_status: got %b required 100", {done, cpu_hold, busy}); end
        checks++; if (words_loaded !== 8'd2) begin errors++; $display("FAIL b2b_words: got %0d required 2", words_loaded); end
        // Bytes offered in DONE must be refused
        rdy_hi = 0;
        bus_if.in_valid = 1'b1; bus_if.in_data = 8'h77;
        repeat (4) begin @(negedge clk); if (bus_if.in_ready !== 1'b0) rdy_hi++; end
        bus_if.in_valid = 1'b0;
        checks++; if (rdy_hi !== 0 || words_loaded !== 8'd2 || wq_data.size() !== 130) begin errors++; $display("FAIL done_refuse: got ready_hi=%0d words=%0d writes=%0d required 0 2 130", rdy_hi, words_loaded, wq_data.size()); end
    endtask

    task automatic test_stalled;
        logic [7:0] prog [0:7];
        int t0, lat;
        prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        clear_q();
        rdy_low = 0;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1; num_words = 8'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(prog[i], 3, (i != 0));
        bus_if.in_valid = 1'b0;
        wait_done(50);
        lat = cyc - t0;
        checks++; if (lat !== 158) begin errors++; $display("FAIL stall_latency: got %0d required 158", lat); end
        repeat (2) @(negedge clk);
        checks++; if (rdy_low !== 0) begin errors++; $display("FAIL stall_ready: got %0d low cycles required 0", rdy_low); end
        checks++; if (wq_data.size() !== 130) begin errors++; $display("FAIL stall_nwrites: got %0d required 130", wq_data.size()); end
        if (wq_data.size() == 130) begin
            checks++; if (wq_data[128] !== 32'h00500513 || wq_addr[128] !== 32'h0) begin errors++; $display("FAIL stall_word0: got %h@%h required 00500513@0", wq_data[128], wq_addr[128]); end
            checks++; if (wq_data[129] !== 32'h00A00593 || wq_addr[129] !== 32'h4) begin errors++; $display("FAIL stall_word1: got %h@%h required 00a00593@4", wq_data[129], wq_addr[129]); end
        end
        checks++; if (words_loaded !== 8'd2 || done !== 1'b1) begin errors++; $display("FAIL stall_status: got words=%0d done=%b required 2 1", words_loaded, done); end
    endtask

    task automatic test_clamp;
        int rdy_hi;
        logic [31:0] j;
        clear_q();
        pulse_start(8'd200);
        for (int i = 0; i < 512; i++) begin
            j = 32'(i);
            send_byte(j[7:0], 0, 1'b0);
        end
        rdy_hi = 0;
        bus_if.in_data = 8'hEE;
        repeat (6) begin @(negedge clk); if (bus_if.in_ready !== 1'b0) rdy_hi++; end
        bus_if.in_valid = 1'b0;
        wait_done(20);
        checks++; if (rdy_hi !== 0) begin errors++; $display("FAIL clamp_refuse: got %0d ready cycles required 0", rdy_hi); end
        checks++; if (wq_data.size() !== 256) begin errors++; $display("FAIL clamp_nwrites: got %0d required 256", wq_data.size()); end
        if (wq_data.size() == 256) begin
            checks++; if (wq_data[255] !== 32'hFFFEFDFC || wq_addr[255] !== 32'd508) begin errors++; $display("FAIL clamp_last: got %h@%0d required fffefdfc@508", wq_data[255], wq_addr[255]); end
            checks++; if (wq_data[129] !== 32'h07060504 || wq_addr[129] !== 32'd4) begin errors++; $display("FAIL clamp_word1: got %h@%0d required 07060504@4", wq_data[129], wq_addr[129]); end
        end
        checks++; if (words_loaded !== 8'd128) begin errors++; $display("FAIL clamp_words: got %0d required 128", words_loaded); end
    endtask

    task automatic test_zero_words;
        int t0, lat;
        clear_q();
        @(negedge clk);
        t0 = cyc;
        start = 1'b1; num_words = 8'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_busy: got busy=%b done=%b required 1 0", busy, done); end
        start = 1'b1; num_words = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        lat = cyc - t0;
        checks++; if (lat !== 129) begin errors++; $display("FAIL zero_latency: got %0d required 129", lat); end
        repeat (2) @(negedge clk);
        checks++; if (wq_data.size() !== 128) begin errors++; $display("FAIL zero_nwrites: got %0d required 128", wq_data.size()); end
        if (wq_data.size() == 128) begin
            checks++; if (wq_addr[127] !== 32'd508 || wq_data[127] !== 32'h0000000D) begin errors++; $display("FAIL zero_last: got %h@%0d required 0000000d@508", wq_data[127], wq_addr[127]); end
        end
        checks++; if (words_loaded !== 8'd0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_status: got words=%0d hold=%b required 0 0", words_loaded, cpu_hold); end
    endtask

    task automatic test_abort;
        logic [7:0] p1 [0:5];
        logic [7:0] p2 [0:3];
        p1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        p2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pulse_start(8'd3);
        for (int i = 0; i < 6; i++) send_byte(p1[i], 0, 1'b0);
        bus_if.in_valid = 1'b0;
        checks++; if (words_loaded !== 8'd1) begin errors++; $display("FAIL abort_pre: got words=%0d required 1", words_loaded); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus_if.in_ready, bus_if.wr_en, done} !== 3'b000) begin errors++; $display("FAIL abort_rst: got ready/wr/done=%b required 000", {bus_if.in_ready, bus_if.wr_en, done}); end
        checks++; if (cpu_hold !== 1'b1 || words_loaded !== 8'd0) begin errors++; $display("FAIL abort_rst_hold: got hold=%b words=%0d required 1 0", cpu_hold, words_loaded); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL abort_hold: got %b required 1", cpu_hold); end
        clear_q();
        pulse_start(8'd1);
        for (int i = 0; i < 4; i++) send_byte(p2[i], 0, 1'b0);
        bus_if.in_valid = 1'b0;
        wait_done(20);
        repeat (2) @(negedge clk);
        checks++; if (wq_data.size() !== 129) begin errors++; $display("FAIL abort_nwrites: got %0d required 129", wq_data.size()); end
        if (wq_data.size() == 129) begin
            checks++; if (wq_data[128] !== 32'hDDCCBBAA || wq_addr[128] !== 32'h0) begin errors++; $display("FAIL abort_word: got %h@%h required ddccbbaa@0", wq_data[128], wq_addr[128]); end
        end
        checks++; if (words_loaded !== 8'd1) begin errors++; $display("FAIL abort_words: got %0d required 1", words_loaded); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stalled();
        test_clamp();
        test_zero_words();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs the bytes into little-endian 32-bit words. It drives the memory's write port with word-aligned byte addresses, the same addressing as the PC. Optionally it first fills every word with the NOP pattern, and it holds the core (cpu_hold) until loading completes.

Parameters:
DEPTH, 128, number of 32-bit words in instruction memory
CNT_W, 8, width of word counters; must satisfy 2^CNT_W > DEPTH
NOP_WORD, 32'h0000000D, fill pattern written during CLEAR
FILL_EN, 1, 1 = run CLEAR before LOAD; 0 = skip CLEAR

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a load
num_words  input  CNT_W  number of words to load; sampled on an accepted start
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte
wr_en  output  1  instruction-memory write strobe
wr_addr  output  32  byte address, always a multiple of 4
wr_data  output  32  write data
words_loaded  output  CNT_W  program words written in the current load
busy  output  1  state is CLEAR or LOAD
done  output  1  level; load complete
cpu_hold  output  1  core must stay stalled while high

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready, wr_en, busy, done = 0.
  - wr_addr, wr_data, words_loaded = 0; cpu_hold = 1.
  - Internal byte index and word index = 0.
- States: IDLE, CLEAR, LOAD, DONE. All outputs are registered.
- start is accepted only in IDLE or DONE; in CLEAR or LOAD it is ignored.
- On an accepted start:
  - Latch N = min(num_words, DEPTH).
  - Clear done and words_loaded; set cpu_hold=1.
  - Next state is CLEAR if FILL_EN=1, otherwise LOAD.
- CLEAR:
  - For k = 0..DEPTH-1, one write per cycle: wr_en=1, wr_addr=4k, wr_data=NOP_WORD. Lasts exactly DEPTH cycles.
  - in_ready=0 throughout.
  - After the write at k=DEPTH-1: go to LOAD, or to DONE if N=0.
- LOAD:
  - in_ready=1 every cycle in LOAD. A byte transfers when in_valid && in_ready.
  - Byte i of a word (i=0..3) goes to bits [8i+7:8i] (little-endian).
  - The cycle after the 4th byte's handshake: wr_en=1 (one cycle), wr_addr=4*word_idx, wr_data=assembled word.
  - In that same cycle words_loaded increments and word_idx increments; a new byte may be accepted in that cycle.
  - If the handshake was for word N-1: in_ready=0 from the next cycle (no further bytes accepted) and state becomes DONE in the cycle wr_en is high.
  - With FILL_EN=0 and N=0, LOAD goes to DONE immediately without accepting bytes.
  - Gaps in in_valid stall assembly indefinitely; there is no timeout.
- DONE:
  - done=1; cpu_hold=0 from the first DONE cycle; in_ready=0; wr_en=0.
  - Bytes presented while in DONE or IDLE are not accepted.
- Write port:
  - wr_en is never high in IDLE or DONE, except the single final LOAD write cycle described above.
  - wr_addr and wr_data hold their last values when wr_en=0.
- Reset mid-CLEAR or mid-LOAD:
  - Immediately returns to reset state; any partial word is discarded.
  - Memory contents are then undefined and cpu_hold stays 1.
- Latency, FILL_EN=1, N words, no stalls: DEPTH + 4N + 1 cycles from start to done.

Test Plan:
- Reset: rst_n=0 mid-simulation -> in_ready=0, wr_en=0, done=0, cpu_hold=1, words_loaded=0 without waiting for a clk edge.
- FILL_EN=1, start with num_words=2, stream 13 05 50 00 93 05 A0 00 with in_valid always high:
  - 128 writes of 0x0000000D at addresses 0..508.
  - Then wr_data=0x00500513 @0 and 0x00A00593 @4.
  - done=1, cpu_hold=0, words_loaded=2.
- Same stream with in_valid low 3 cycles between every byte -> identical writes and data; the only difference is timing; in_ready is never low while in LOAD.
- num_words=200 -> N clamped to 128: last write at wr_addr=508; the 129th word's bytes are not accepted (in_ready=0); words_loaded=128.
- num_words=0 with FILL_EN=1 -> only the CLEAR writes occur, then done=1; start pulsed during CLEAR is ignored (no restart, done timing unchanged).
- Start a 3-word load, assert rst_n=0 after 6 bytes, release, start a 1-word load with AA BB CC DD -> first LOAD write is 0xDDCCBBAA at wr_addr=0; no stale bytes from the aborted load.
